// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner with debounced press and release
// One row is driven low per scan tick; a key is reported once its column stays low for DEBOUNCE_CNT ticks.
module keypad_scanner #(
   parameter int SCAN_DIV     = 27000,
   parameter int DEBOUNCE_CNT = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col_n,
   output logic [3:0] row_n,
   output logic [4:0] key,
   output logic       keypad_pressed,
   output logic       key_held
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

   state_t        state_q, state_d;
   logic [3:0]    sync1_q, sync2_q;
   logic [DW-1:0] div_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    row_q, row_d;
   logic [1:0]    col_q, col_d;
   logic [3:0]    row_n_q, row_n_d;
   logic [4:0]    key_q, key_d;
   logic          pressed_q, pressed_d;
   logic          held_q, held_d;
   logic          tick;
   logic          any_low;
   logic          col_low;
   logic [1:0]    low_idx;

   assign tick    = (div_q == DIV_MAX);
   assign any_low = (sync2_q != 4'hF);
   assign col_low = ~sync2_q[col_q];

   // Lowest-index column wins when several are pressed on the same row.
   always_comb begin
      low_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!sync2_q[i]) low_idx = 2'(i);
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      row_d     = row_q;
      col_d     = col_q;
      key_d     = key_q;
      pressed_d = 1'b0;
      held_d    = held_q;
      if (tick) begin
         case (state_q)
            S_SCAN: begin
               if (any_low) begin
                  col_d = low_idx;
                  cnt_d = CNT_ONE;
                  if (DEBOUNCE_CNT == 1) begin
                     key_d     = {1'b0, row_q, low_idx};
                     pressed_d = 1'b1;
                     held_d    = 1'b1;
                     cnt_d     = '0;
                     state_d   = S_HELD;
                  end else begin
                     state_d = S_DEBOUNCE;
                  end
               end else begin
                  row_d = row_q + 2'd1;
               end
            end
            S_DEBOUNCE: begin
               if (!col_low) begin
                  cnt_d   = '0;
                  row_d   = row_q + 2'd1;
                  state_d = S_SCAN;
               end else if (cnt_q + CNT_ONE == CNT_MAX) begin
                  key_d     = {1'b0, row_q, col_q};
                  pressed_d = 1'b1;
                  held_d    = 1'b1;
                  cnt_d     = '0;
                  state_d   = S_HELD;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            S_HELD: begin
               if (!col_low) begin
                  if (DEBOUNCE_CNT == 1) begin
                     key_d   = 5'h1F;
                     held_d  = 1'b0;
                     cnt_d   = '0;
                     row_d   = row_q + 2'd1;
                     state_d = S_SCAN;
                  end else begin
                     cnt_d   = CNT_ONE;
                     state_d = S_RELEASE;
                  end
               end
            end
            default: begin
               if (col_low) begin
                  cnt_d   = '0;
                  state_d = S_HELD;
               end else if (cnt_q + CNT_ONE == CNT_MAX) begin
                  key_d   = 5'h1F;
                  held_d  = 1'b0;
                  cnt_d   = '0;
                  row_d   = row_q + 2'd1;
                  state_d = S_SCAN;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         endcase
      end
      row_n_d = ~(4'b0001 << row_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_SCAN;
         sync1_q   <= 4'hF;
         sync2_q   <= 4'hF;
         div_q     <= '0;
         cnt_q     <= '0;
         row_q     <= 2'd0;
         col_q     <= 2'd0;
         row_n_q   <= 4'b1110;
         key_q     <= 5'h1F;
         pressed_q <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= col_n;
         sync2_q   <= sync1_q;
         div_q     <= tick ? '0 : div_q + 1'b1;
         cnt_q     <= cnt_d;
         row_q     <= row_d;
         col_q     <= col_d;
         row_n_q   <= row_n_d;
         key_q     <= key_d;
         pressed_q <= pressed_d;
         held_q    <= held_d;
      end
   end

   assign row_n          = row_n_q;
   assign key            = key_q;
   assign keypad_pressed = pressed_q;
   assign key_held       = held_q;

endmodule
